// File: rtl/bit_array_packer_pkg.sv
// Shared shape constants and types for the bit-serial array packer.
// Build option: BIT_ARRAY_PACKER_PARITY_EN appends an even-parity bit per word.
package bit_array_packer_pkg;

    localparam int DEF_ROWS  = 5;
    localparam int DEF_COLS  = 4;
    localparam int DEF_DEPTH = 3;
    localparam int W         = DEF_ROWS * DEF_COLS * DEF_DEPTH;

    typedef logic [0:DEF_ROWS-1][DEF_COLS-1:0][1:DEF_DEPTH] word_t;
    typedef logic [$clog2(W+1)-1:0] cnt_t;

    // Serial bits per word, including the parity bit when enabled
    function automatic int serial_bits(input int data_bits);
`ifdef BIT_ARRAY_PACKER_PARITY_EN
        return data_bits + 1;
`else
        return data_bits;
`endif
    endfunction

endpackage

// File: rtl/bit_array_packer_ostage.sv
// Output register plus one-deep pending slot and output sequence counter.
// Keeps word order while letting the input side run under backpressure.
module bit_array_packer_ostage #(
    parameter int W     = 60,
    parameter int SEQ_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             in_perr,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [W-1:0]     m_data,
    output logic             m_perr,
    output logic [SEQ_W-1:0] m_seq,
    output logic             pend_valid
);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_perr_q, out_perr_d;
    logic             pend_valid_q, pend_valid_d;
    logic [W-1:0]     pend_data_q, pend_data_d;
    logic             pend_perr_q, pend_perr_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             fire;

    assign fire = out_valid_q && m_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_perr_d   = out_perr_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_perr_d  = pend_perr_q;
        seq_d        = seq_q + SEQ_W'(fire);
        if (pend_valid_q) begin
            if (fire) begin
                out_data_d = pend_data_q;
                out_perr_d = pend_perr_q;
                // a word finishing now refills the slot being vacated
                if (in_valid) begin
                    pend_data_d = in_data;
                    pend_perr_d = in_perr;
                end else begin
                    pend_valid_d = 1'b0;
                end
            end
        end else if (in_valid) begin
            if (!out_valid_q || m_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_perr_d  = in_perr;
            end else begin
                pend_valid_d = 1'b1;
                pend_data_d  = in_data;
                pend_perr_d  = in_perr;
            end
        end else if (fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_perr_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_perr_q  <= 1'b0;
            seq_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_perr_q   <= out_perr_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_perr_q  <= pend_perr_d;
            seq_q        <= seq_d;
        end
    end

    assign m_valid    = out_valid_q;
    assign m_data     = out_data_q;
    assign m_perr     = out_perr_q;
    assign m_seq      = seq_q;
    assign pend_valid = pend_valid_q;

endmodule

// File: rtl/bit_array_packer.sv
// Serial-to-parallel packer: MSB-first shift into a [0:R-1][C-1:0][1:D] word.
// Build option: BIT_ARRAY_PACKER_PARITY_EN adds a trailing even-parity bit.
module bit_array_packer
    import bit_array_packer_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SEQ_W = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_bit,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic                                  flush,
    output logic [0:ROWS-1][COLS-1:0][1:DEPTH]    m_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [SEQ_W-1:0]                      m_seq,
    output logic                                  m_perr
);

    localparam int WL = ROWS * COLS * DEPTH;
    localparam int NB = serial_bits(WL);
    localparam int CW = $clog2(NB + 1);

    logic [WL-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          last;
    logic [WL-1:0] done_word;
    logic          done_perr;
    logic [WL-1:0] out_flat;
    logic          pend_valid;

    assign s_ready = !pend_valid && !rst;
    assign accept  = s_valid && s_ready && !flush;
    assign last    = accept && (cnt_q == CW'(NB - 1));

`ifdef BIT_ARRAY_PACKER_PARITY_EN
    // final serial bit is parity only; data is already fully shifted in
    assign done_word = sr_q;
    assign done_perr = (^sr_q) ^ s_bit;
`else
    assign done_word = {sr_q[WL-2:0], s_bit};
    assign done_perr = 1'b0;
`endif

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (flush) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (last) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (accept) begin
            sr_d  = {sr_q[WL-2:0], s_bit};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    bit_array_packer_ostage #(
        .W     (WL),
        .SEQ_W (SEQ_W)
    ) u_ostage (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (last),
        .in_data    (done_word),
        .in_perr    (done_perr),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (out_flat),
        .m_perr     (m_perr),
        .m_seq      (m_seq),
        .pend_valid (pend_valid)
    );

    assign m_data = out_flat;

endmodule

// File: tb/tb_bit_array_packer.sv
// Self-checking bench: directed tables and sequences plus random traffic
// scored against a queue-based word model.
module tb_bit_array_packer;
    import bit_array_packer_pkg::*;

`ifdef BIT_ARRAY_PACKER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_bit = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       flush = 1'b0;
    word_t      m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [3:0] m_seq;
    logic       m_perr;
    logic [W-1:0] m_flat;

    assign m_flat = m_data;

    bit_array_packer dut (
        .clk     (clk),
        .rst     (rst),
        .s_bit   (s_bit),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .flush   (flush),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_seq   (m_seq),
        .m_perr  (m_perr)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    logic [W-1:0] acc;
    int           idx;
    logic         acc_perr;
    logic [W-1:0] exp_q[$];
    logic         exp_p[$];
    int           exp_seq;
    int           hs_count;
    int           cyc;
    int           hs_cyc_q[$];
    logic [W-1:0] last_out;
    logic         last_perr;
    logic [3:0]   last_seq;
    logic         hold_v;
    logic [W-1:0] hold_d;
    logic [3:0]   hold_s;
    logic         hold_p;

    typedef struct {
        int           pre_bits;
        bit           flush_on_bit;
        logic [W-1:0] word;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        acc = '0;
        idx = 0;
        acc_perr = 1'b0;
        exp_q.delete();
        exp_p.delete();
        exp_seq = 0;
        hold_v = 1'b0;
        hs_cyc_q.delete();
    endtask

    task automatic step(input logic sv, input logic sb, input logic fl,
                        input logic mr);
        logic [W-1:0] e;
        logic         ep;
        @(negedge clk);
        s_valid = sv;
        s_bit   = sb;
        flush   = fl;
        m_ready = mr;
        #1;
        cyc++;
        if (hold_v) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_flat, hold_d);
            chk("hold_seq", m_seq, hold_s);
            chk("hold_perr", m_perr, hold_p);
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_flat;
        hold_s = m_seq;
        hold_p = m_perr;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", m_flat, 0);
            end else begin
                e  = exp_q.pop_front();
                ep = exp_p.pop_front();
                chk("m_data", m_flat, e);
                chk("m_seq", m_seq, exp_seq[3:0]);
                chk("m_perr", m_perr, ep);
            end
            last_out  = m_flat;
            last_perr = m_perr;
            last_seq  = m_seq;
            exp_seq   = (exp_seq + 1) % 16;
            hs_count++;
            hs_cyc_q.push_back(cyc);
        end
        if (fl) begin
            acc = '0;
            idx = 0;
        end else if (sv && s_ready) begin
            if (idx < W) acc[W-1-idx] = sb;
            else acc_perr = (^acc) ^ sb;
            idx++;
            if (idx == NB) begin
                exp_q.push_back(acc);
                exp_p.push_back(NB == W ? 1'b0 : acc_perr);
                acc = '0;
                idx = 0;
            end
        end
    endtask

    task automatic send_bit(input logic b, input logic mr);
        int n;
        n = 0;
        while (n < 200) begin
            step(1'b1, b, 1'b0, mr);
            if (s_ready) break;
            n++;
        end
        if (n == 200) chk("send_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic mr,
                             input logic pflip);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], mr);
        if (NB > W) send_bit((^w) ^ pflip, mr);
    endtask

    task automatic wait_out();
        int h;
        int n;
        h = hs_count;
        n = 0;
        while (hs_count == h && n < 10) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        if (hs_count == h) chk("wait_out_timeout", 0, 1);
    endtask

    task automatic do_reset(input bit check_async);
        @(negedge clk);
        s_valid = 1'b0;
        flush   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        if (check_async) begin
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_flat, 0);
            chk("rst_m_seq", m_seq, 0);
            chk("rst_m_perr", m_perr, 0);
            chk("rst_s_ready", s_ready, 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        cyc = 0;
        hs_count = 0;
        last_out = '0;
        last_perr = 1'b0;
        last_seq = '0;
        model_reset();

        tbl[0] = '{0,  1'b0, 60'h7FF_FFFF_FFFF_FFFF, 60'h7FF_FFFF_FFFF_FFFF};
        tbl[1] = '{30, 1'b0, 60'hA5A_5A5A_5A5A_5A5A, 60'hA5A_5A5A_5A5A_5A5A};
        tbl[2] = '{30, 1'b1, 60'hA5A_5A5A_5A5A_5A5A, 60'hA5A_5A5A_5A5A_5A5A};
        tbl[3] = '{59, 1'b1, 60'h123_4567_89AB_CDEF, 60'h123_4567_89AB_CDEF};
        tbl[4] = '{0,  1'b0, 60'h000_0000_0000_0001, 60'h000_0000_0000_0001};
        tbl[5] = '{10, 1'b0, 60'hFFF_FFFF_FFFF_FFFF, 60'hFFF_FFFF_FFFF_FFFF};

        do_reset(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_flat, 0);
        chk("reset_m_seq", m_seq, 0);
        chk("reset_s_ready", s_ready, 1);

        // zero then 59 ones, output one clock after the last bit
        send_word(60'h7FF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("latency_valid", m_valid, 1);
        chk("first_data", m_flat, 60'h7FF_FFFF_FFFF_FFFF);
        chk("elem_0_3_1", m_data[0][3][1], 0);
        chk("first_seq", m_seq, 0);
        wait_out();

        // backpressure: second word parks in pend, input stalls
        do_reset(1'b0);
        w1 = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        send_word(w1, 1'b0, 1'b0);
        send_word(w2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            chk("stall_s_ready", s_ready, 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_word1", last_out, w1);
        chk("bp_seq1", last_seq, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_word2", last_out, w2);
        chk("bp_seq2", last_seq, 1);
        chk("bp_count", hs_count, 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drain_valid", m_valid, 0);

        // 17 back-to-back words, sequence wraps, no bubbles
        do_reset(1'b0);
        for (int k = 0; k < 17; k++) begin
            w = {$urandom, $urandom};
            send_word(w, 1'b1, 1'b0);
        end
        wait_out();
        chk("wrap_seq", last_seq, 0);
        chk("wrap_count", hs_cyc_q.size(), 17);
        for (int k = 1; k < hs_cyc_q.size(); k++)
            chk("no_bubble", hs_cyc_q[k] - hs_cyc_q[k-1], NB);

        // table: partial words discarded by flush
        do_reset(1'b0);
        foreach (tbl[i]) begin
            for (int b = 0; b < tbl[i].pre_bits; b++)
                send_bit(1'($urandom), 1'b1);
            if (tbl[i].flush_on_bit) step(1'b1, 1'b1, 1'b1, 1'b1);
            else if (tbl[i].pre_bits > 0) step(1'b0, 1'b0, 1'b1, 1'b1);
            send_word(tbl[i].word, 1'b1, 1'b0);
            wait_out();
            chk("table_word", last_out, tbl[i].exp);
            chk("table_single", exp_q.size(), 0);
        end

        // async reset mid-word
        do_reset(1'b0);
        for (int b = 0; b < 40; b++) send_bit(1'b1, 1'b1);
        do_reset(1'b1);

        // async reset mid-stall, after a handshake moved m_seq
        send_word({$urandom, $urandom}, 1'b1, 1'b0);
        wait_out();
        send_word({$urandom, $urandom}, 1'b0, 1'b0);
        send_word({$urandom, $urandom}, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_stall", s_ready, 0);
        do_reset(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_ready", s_ready, 1);
        chk("post_rst_valid", m_valid, 0);
        send_word(60'hA5A_5A5A_5A5A_5A5A, 1'b1, 1'b0);
        wait_out();
        chk("post_rst_word", last_out, 60'hA5A_5A5A_5A5A_5A5A);
        chk("post_rst_seq", last_seq, 0);

`ifdef BIT_ARRAY_PACKER_PARITY_EN
        send_word(60'h1, 1'b1, 1'b0);
        wait_out();
        chk("parity_ok", last_perr, 0);
        send_word(60'h1, 1'b1, 1'b1);
        wait_out();
        chk("parity_err", last_perr, 1);
`endif

        // random traffic against the model
        do_reset(1'b0);
        for (int i = 0; i < 4000; i++)
            step(($urandom % 4) != 0, 1'($urandom),
                 ($urandom % 300) == 0, ($urandom % 3) != 0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("random_drain", exp_q.size(), 0);
        chk("random_idle", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/bit_array_packer.md
Name: bit_array_packer

Overview:
- Serial-to-parallel packer: accepts a 1-bit stream with valid/ready and assembles it into a multi-dimensional packed array word of shape [0:ROWS-1][COLS-1:0][1:DEPTH] (default 5x4x3 = 60 bits).
- Provides the word-building direction for blocks that take such arrays as inputs and reduce them to a single bit.
- Sits between a bit-serial source and any consumer of the packed array. Holds one completed word in a pending slot so input can continue under output backpressure.

Parameters:
- ROWS, 5, outer (first) packed dimension, indexed 0..ROWS-1
- COLS, 4, middle packed dimension, indexed COLS-1..0
- DEPTH, 3, inner packed dimension, indexed 1..DEPTH
- SEQ_W, 4, width of output word sequence counter

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- s_bit  input  1  serial data bit
- s_valid  input  1  s_bit valid
- s_ready  output  1  packer can accept s_bit
- flush  input  1  synchronous; discards partially assembled word
- m_data  output  W=ROWS*COLS*DEPTH  assembled word, type word_t
- m_valid  output  1  m_data valid
- m_ready  input  1  consumer accepts m_data
- m_seq  output  SEQ_W  index of word currently on m_data
- m_perr  output  1  parity error for word on m_data; tied 0 when feature is compiled out

Behaviour:
- Fill order is MSB-first. First accepted bit of a word lands at element [0][COLS-1][1] (m_data[W-1]); last bit lands at [ROWS-1][0][DEPTH] (m_data[0]). Implemented as a left shift register with a bit counter running 0..W-1.
- A bit is accepted when s_valid && s_ready. Accepting bit W-1 completes the word.
- Completed word goes straight to the output register if !m_valid || m_ready in that cycle. Otherwise it goes to the pending register and pend_valid is set.
- s_ready = !pend_valid && !rst. Input stalls only when both the output register and the pending slot are occupied.
- Output register reloads from pend when m_valid && m_ready && pend_valid. If the final bit of the next word completes in that same cycle, pend takes the new word. Ordering is always preserved.
- Latency: final bit accepted in cycle N gives m_valid=1 in cycle N+1.
- Throughput: 1 bit/clk. Back-to-back words produce m_valid every W clocks with no bubble.
- m_valid drops after an output handshake unless a new word is loaded in the same cycle.
- m_data, m_seq and m_perr are stable while m_valid && !m_ready.
- m_seq increments on each output handshake and wraps 2^SEQ_W-1 -> 0.
- flush zeroes the bit counter and shift register. It does not affect m_data or pend. flush together with an accepted bit: flush wins and the bit is discarded.
- Reset (async, mid-word or mid-handshake): m_valid=0, m_data=0, m_seq=0, m_perr=0, pend_valid=0, bit counter 0. Any partial word is lost. s_ready=1 from the first clock after rst deasserts.

Optional Feature:
- Macro: BIT_ARRAY_PACKER_PARITY_EN.
- With the macro: each word is W+1 serial bits. Bit W is an even-parity bit over the W data bits and is not stored. The bit counter runs 0..W and the word completes on the parity bit. m_perr = (XOR of data bits) ^ parity bit, registered and carried through pend alongside m_data.
- Without the macro: words are W bits and m_perr is constant 0.

Decomposition:
- Package bit_array_packer_pkg holds:
  - default ROWS/COLS/DEPTH localparams;
  - typedef word_t logic [0:ROWS-1][COLS-1:0][1:DEPTH];
  - W constant;
  - cnt_t sized $clog2(W+1).
- One sub-module, bit_array_packer_ostage, holds the output register, pending slot, m_seq counter and load/advance logic. The top level keeps the shift register, bit counter and flush.

Test Plan:
- Reset then 60 bits: 0 followed by 59 ones, m_ready=1 -> m_valid one clk after the last bit; m_data=60'h7FF_FFFF_FFFF_FFFF, m_data[0][3][1]=0; m_seq=0.
- m_ready=0; send 2 words, then continue s_valid -> second word held in pend; s_ready=0 from the clk after word 2 completes. Raising m_ready gives word1 then word2 in order, m_seq 0 then 1, no bits lost.
- 17 consecutive words with m_ready=1 -> m_seq reads 0..15, 0; continuous input shows no bubble.
- 30 bits, flush, then 60 bits of pattern 60'hA5A_5A5A_5A5A_5A5A -> single output word equal to that pattern; flush asserted on an accepted bit discards that bit.
- rst asserted after 40 bits and mid-stall -> all outputs 0 immediately (asynchronous). A fresh 60-bit word afterwards is assembled correctly.
- PARITY_EN: word 60'h1 with parity 1 -> m_perr=0; same word with parity 0 -> m_perr=1.
